// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared constants, state encoding and pass-step helper
package shift_sequencer_pkg;

  localparam int DATA_W   = 8;
  localparam int AMT_W    = 5;
  localparam int STEP_MAX = 7;
  localparam int PASS_W   = 3;

  // 2'd3 is unused and is treated as idle by the decode
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Largest shift the 3-bit shifter can do this pass without overshooting
  function automatic logic [2:0] pass_step(input logic [AMT_W-1:0] rem);
    return (rem > AMT_W'(STEP_MAX)) ? 3'(STEP_MAX) : rem[2:0];
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - 8-bit logical barrel shifter, 0..7 positions, zero fill
module barrel_shifter #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  input  logic [2:0]   shamt,
  input  logic         dir,
  output logic [W-1:0] dout
);

  // dir=1 shifts toward the MSB, dir=0 toward the LSB
  assign dout = dir ? (din << shamt) : (din >> shamt);

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - splits 0..31 shift commands into passes of at most 7
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PASS_W-1:0] out_passes,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic              dir_q, dir_d;
  logic [PASS_W-1:0] passes_q, passes_d;

  logic [2:0]        step;
  logic [AMT_W-1:0]  rem_next;
  logic [DATA_W-1:0] bs_out;

  assign step     = pass_step(rem_q);
  assign rem_next = rem_q - {2'b00, step};

  barrel_shifter #(.W(DATA_W)) u_bs (
    .din   (data_q),
    .shamt (step),
    .dir   (dir_q),
    .dout  (bs_out)
  );

  // Next-state: latch command in idle, one shifter pass per cycle, hold until taken
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    passes_d = passes_q;
    case (state_q)
      ST_SHIFT: begin
        data_d   = bs_out;
        rem_d    = rem_next;
        passes_d = passes_q + 3'd1;
        if (rem_next == '0) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (in_valid) begin
          data_d   = in_data;
          dir_d    = in_dir;
          rem_d    = in_amt;
          passes_d = '0;
          state_d  = (in_amt == '0) ? ST_HOLD : ST_SHIFT;
        end
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      passes_q <= passes_d;
    end
  end

  assign busy       = (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign in_ready   = !busy;
  assign out_valid  = (state_q == ST_HOLD);
  assign out_data   = data_q;
  assign out_passes = passes_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_amt;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_passes;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_dir     (in_dir),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_passes (out_passes),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of a full logical shift by 0..31 in one step
  function automatic logic [7:0] model_shift(input logic [7:0] d, input int amt, input logic dir);
    logic [39:0] w;
    logic [7:0]  r;
    w = {32'b0, d};
    if (amt >= 8) return 8'h00;
    w = dir ? (w << amt) : (w >> amt);
    r = w[7:0];
    return r;
  endfunction

  // Transaction-level model: accept edge, pass count, release edge
  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_acc = 0;
  int         m_p = 0;
  logic [7:0] m_data = 8'h00;
  int         acc_cnt = 0;
  int         acc_log[$];
  logic [10:0] res_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_active) begin
        if (out_ready && (cyc + 1 > m_acc + m_p)) m_active <= 1'b0;
      end else if (in_valid) begin
        m_active <= 1'b1;
        m_acc    <= cyc + 1;
        m_p      <= (int'(in_amt) + 6) / 7;
        m_data   <= model_shift(in_data, int'(in_amt), in_dir);
        acc_cnt  <= acc_cnt + 1;
        acc_log.push_back(cyc + 1);
      end
    end
  end

  // Every cycle out of reset: handshake/status outputs and, when valid, the result
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!m_active));
      check("busy", 32'(busy), 32'(m_active));
      check("out_valid", 32'(out_valid), 32'(m_active && (cyc >= m_acc + m_p)));
      if (m_active && (cyc >= m_acc + m_p)) begin
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_passes", 32'(out_passes), 32'(m_p));
      end
      if (out_valid && out_ready) res_log.push_back({out_passes, out_data});
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return 1ns after the edge that accepted it; in_valid stays high
  task automatic send(input logic [7:0] d, input logic [4:0] a, input logic dir);
    int start;
    start    = acc_cnt;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    for (int i = 0; i < 200 && acc_cnt == start; i++) step_cyc();
    if (acc_cnt == start) check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 5'd0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_passes", 32'(out_passes), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step_cyc();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: 0xB5 << 3, one pass
    out_ready = 1'b1;
    send(8'hB5, 5'd3, 1'b1);
    in_valid = 1'b0;
    check("t1_lat_low", 32'(out_valid), 32'd0);
    step_cyc();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'hA8);
    check("t1_passes", 32'(out_passes), 32'd1);
    step_cyc();

    // 2: 0x80 >> 8 as 7 then 1
    send(8'h80, 5'd8, 1'b0);
    in_valid = 1'b0;
    check("t2_lat_low0", 32'(out_valid), 32'd0);
    step_cyc();
    check("t2_lat_low1", 32'(out_valid), 32'd0);
    step_cyc();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_data", 32'(out_data), 32'h00);
    check("t2_passes", 32'(out_passes), 32'd2);
    step_cyc();

    // 3: zero amount goes straight to hold
    send(8'h5A, 5'd0, 1'b1);
    in_valid = 1'b0;
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_data", 32'(out_data), 32'h5A);
    check("t3_passes", 32'(out_passes), 32'd0);
    step_cyc();

    // 4: 31 positions, five passes, stalled consumer with a competing command
    out_ready = 1'b0;
    send(8'h01, 5'd31, 1'b1);
    in_data = 8'hFF;
    in_amt  = 5'd2;
    in_dir  = 1'b0;
    repeat (5) step_cyc();
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_data", 32'(out_data), 32'h00);
    check("t4_passes", 32'(out_passes), 32'd5);
    for (int i = 0; i < 6; i++) begin
      step_cyc();
      check("t4_in_ready_low", 32'(in_ready), 32'd0);
      check("t4_passes_stable", 32'(out_passes), 32'd5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step_cyc();
    check("t4_released", 32'(out_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);

    // 5: reset in the middle of a 20-position command
    send(8'hC3, 5'd20, 1'b1);
    in_valid = 1'b0;
    step_cyc();
    check("t5_in_shift", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_out_data", 32'(out_data), 32'd0);
    check("t5_out_passes", 32'(out_passes), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step_cyc();
    check("t5_in_ready", 32'(in_ready), 32'd1);

    // 6: back-to-back commands on 0xFF, right shifts of 7, 14, 1
    res_log.delete();
    n0 = acc_log.size();
    out_ready = 1'b1;
    send(8'hFF, 5'd7, 1'b0);
    send(8'hFF, 5'd14, 1'b0);
    send(8'hFF, 5'd1, 1'b0);
    in_valid = 1'b0;
    repeat (4) step_cyc();
    check("t6_count", 32'(res_log.size()), 32'd3);
    check("t6_res0", 32'(res_log[0]), 32'({3'd1, 8'h01}));
    check("t6_res1", 32'(res_log[1]), 32'({3'd2, 8'h00}));
    check("t6_res2", 32'(res_log[2]), 32'({3'd1, 8'h7F}));
    check("t6_gap0", 32'(acc_log[n0 + 1] - acc_log[n0]), 32'd3);
    check("t6_gap1", 32'(acc_log[n0 + 2] - acc_log[n0 + 1]), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
